l2_cache_ctrl_nway: RTL and testbench
=====================================

// Module: l2_cache_ctrl_nway
// PURPOSE
//   Control FSM for the parametrised N-way, write-back, write-allocate L2 cache. Sits between the L1/arbiter
//   request port and physical memory. Drives the datapath's way-select, write-enable, dirty and address muxes.
//   Keeps tree-PLRU state for every set internally and picks the victim (first invalid way, else PLRU).
//   Flags protocol errors.
// PARAMETERS
//   WAYS      4   associativity; power of two, 2..16
//   SETS      8   number of sets; power of two
//   IDX_W     $clog2(SETS)   set index width (derived, do not override)
//   WAY_W     $clog2(WAYS)   way index width (derived)
// PORTS
//   clk            in   1      clock; all state on rising edge
//   rst_n          in   1      asynchronous, active-low reset
//   mem_read       in   1      upstream read request; held until mem_resp
//   mem_write      in   1      upstream write request; held until mem_resp
//   set_idx        in   IDX_W  set index of the current request; stable while request held
//   hit_vec        in   WAYS   per-way tag-match AND valid for set_idx
//   valid_vec      in   WAYS   per-way valid bits for set_idx
//   dirty_vec      in   WAYS   per-way dirty bits for set_idx
//   pmem_resp      in   1      memory done; level, may stay high for >1 cycle
//   mem_resp       out  1      one-cycle upstream completion pulse
//   pmem_read      out  1      memory line read request
//   pmem_write     out  1      memory line write-back request
//   way_idx        out  WAY_W  way addressed by the datapath (hit way or latched victim)
//   data_we        out  WAYS   one-hot data-array write enable
//   data_in_sel    out  1      0 = upstream write data, 1 = pmem fill line
//   tag_we         out  1      load tag + set valid for way_idx
//   ld_dirty       out  1      load dirty bit of way_idx
//   dirty_in       out  1      value for ld_dirty
//   address_sel    out  1      1 = request address to pmem, 0 = victim tag address
//   err_rw         out  1      pulse: mem_read and mem_write both high in IDLE
//   err_multi_hit  out  WAYS>1 ? 1 : 1   pulse: >1 bit set in hit_vec in COMPARE
// BEHAVIOUR
//   Reset (rst_n low, any state): state=IDLE; all PLRU bits 0; victim reg 0; every output 0 except address_sel=1.
//   Reset mid-miss abandons the transaction. No mem_resp is produced. pmem_* drop asynchronously.
//   States:
//   IDLE: exactly one of mem_read/mem_write -> COMPARE.
//     Both high -> err_rw=1 for that cycle, stay IDLE, request not serviced.
//   COMPARE, hit (|hit_vec): way_idx = lowest set bit of hit_vec; mem_resp=1; update PLRU[set_idx] toward hit way.
//     On a write hit also: data_we=onehot(way_idx), data_in_sel=0, ld_dirty=1, dirty_in=1.
//     Next state IDLE. Popcount(hit_vec)>1 -> err_multi_hit=1, lowest index still used.
//   COMPARE, miss: victim = lowest-index invalid way if ~&valid_vec, else PLRU victim of set_idx.
//     Victim is latched at the COMPARE->next edge. Victim dirty (valid and dirty) -> WRITE_BACK, else ALLOCATE.
//   WRITE_BACK: pmem_write=1, address_sel=0, way_idx=victim. pmem_resp -> WB_HOLD.
//   WB_HOLD: all requests low; wait until pmem_resp==0 -> ALLOCATE.
//   ALLOCATE: pmem_read=1, address_sel=1, way_idx=victim. pmem_resp -> FILL.
//   FILL (one cycle's write, then hold): data_we=onehot(victim), data_in_sel=1, tag_we=1, ld_dirty=1, dirty_in=0.
//     Stay while pmem_resp==1 (writes repeat idempotently); pmem_resp==0 -> COMPARE.
//   Re-entry to COMPARE after FILL hits, so the response path is identical for hit and miss.
//   Latency, request seen in IDLE at cycle 0:
//     hit: mem_resp in cycle 1.
//     clean miss: mem_resp 2 cycles after pmem_resp falls.
//   PLRU: WAYS-1 bits per set; node bit 0 = left subtree is LRU.
//     Update on every mem_resp; bits are never touched on miss states.
//   mem_read/mem_write dropping before mem_resp is a protocol violation. FSM completes the line fill regardless,
//   then returns to IDLE from COMPARE with no mem_resp.
//   WAYS==1: PLRU logic is absent; victim is always 0.
// TESTING  (WAYS=4, SETS=8)
//   1. Reset with rst_n=0 mid-ALLOCATE -> pmem_read=0 immediately; state IDLE; next request gets full miss flow.
//   2. Read, hit_vec=4'b0100 -> mem_resp cycle 1, way_idx=2, data_we=0, PLRU[set] updated, no pmem activity.
//   3. Write miss, set 3, valid_vec=4'b1011 -> victim 2, ALLOCATE then FILL data_we=4'b0100.
//      Then COMPARE write-hit with ld_dirty/dirty_in=1.
//   4. All valid, PLRU victim 1, dirty_vec=4'b0010 -> WRITE_BACK with address_sel=0; pmem_resp held 3 cycles.
//      -> one WB_HOLD exit, single ALLOCATE; mem_resp exactly once.
//   5. Four reads filling ways 0..3 in one set, then a miss -> victim = way 0 (true LRU for this sequence).
//   6. mem_read=mem_write=1 -> err_rw pulse, no COMPARE.
//      hit_vec=4'b0011 -> err_multi_hit=1 and way_idx=0.

Source files
------------

// File: rtl/l2_cache_ctrl_nway.sv
// Control FSM for an N-way write-back, write-allocate L2 cache.
// Tracks per-set tree-PLRU state, chooses victims and sequences write-back/fill traffic to memory.
module l2_cache_ctrl_nway #(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    // Held at one bit minimum so a single-way build still has a legal way_idx port
    parameter int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAYS-1:0]  dirty_vec,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [WAY_W-1:0] way_idx,
    output logic [WAYS-1:0]  data_we,
    output logic             data_in_sel,
    output logic             tag_we,
    output logic             ld_dirty,
    output logic             dirty_in,
    output logic             address_sel,
    output logic             err_rw,
    output logic             err_multi_hit
);

    typedef enum logic [2:0] {
        IDLE, COMPARE, WRITE_BACK, WB_HOLD, ALLOCATE, FILL
    } state_t;

    state_t           state;
    logic [WAY_W-1:0] victim;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] plru_way;
    logic [WAY_W-1:0] next_victim;
    logic             req;
    logic             any_hit;
    logic             multi_hit;
    logic             victim_dirty;

    assign req          = mem_read | mem_write;
    assign any_hit      = |hit_vec;
    assign multi_hit    = $countones(hit_vec) > 1;
    assign next_victim  = (&valid_vec) ? plru_way : inv_way;
    assign victim_dirty = valid_vec[next_victim] & dirty_vec[next_victim];

    // Scanning downwards leaves the lowest matching index as the final winner
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i])    hit_way = WAY_W'(i);
            if (!valid_vec[i]) inv_way = WAY_W'(i);
        end
    end

    generate
        if (WAYS > 1) begin : g_plru
            logic [WAYS-2:0]  plru [SETS];
            logic [WAYS-2:0]  plru_row;
            logic [WAYS-2:0]  plru_next;
            logic [WAY_W-1:0] vnode;
            logic [WAY_W-1:0] unode;
            logic [WAY_W-1:0] path;

            assign plru_row = plru[set_idx];

            // Heap-ordered tree: node n has children 2n+1 (left) and 2n+2 (right); a 0 bit points left
            always_comb begin
                vnode    = '0;
                plru_way = '0;
                for (int l = 0; l < WAY_W; l++) begin
                    plru_way = (plru_way << 1) | WAY_W'(plru_row[vnode]);
                    vnode    = WAY_W'(2 * 32'(vnode) + 1 + 32'(plru_row[vnode]));
                end
            end

            // Every node on the accessed path is turned to point away from the hit way
            always_comb begin
                plru_next = plru_row;
                unode     = '0;
                path      = hit_way;
                for (int l = 0; l < WAY_W; l++) begin
                    plru_next[unode] = ~path[WAY_W-1];
                    unode            = WAY_W'(2 * 32'(unode) + 1 + 32'(path[WAY_W-1]));
                    path             = path << 1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SETS; s++) plru[s] <= '0;
                end else if (state == COMPARE && req && any_hit) begin
                    plru[set_idx] <= plru_next;
                end
            end
        end else begin : g_no_plru
            assign plru_way = '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            victim <= '0;
        end else begin
            case (state)
                IDLE:       if (mem_read ^ mem_write) state <= COMPARE;
                COMPARE: begin
                    if (!req || any_hit) begin
                        state <= IDLE;
                    end else begin
                        victim <= next_victim;
                        state  <= victim_dirty ? WRITE_BACK : ALLOCATE;
                    end
                end
                WRITE_BACK: if (pmem_resp)  state <= WB_HOLD;
                WB_HOLD:    if (!pmem_resp) state <= ALLOCATE;
                ALLOCATE:   if (pmem_resp)  state <= FILL;
                FILL:       if (!pmem_resp) state <= COMPARE;
                default:    state <= IDLE;
            endcase
        end
    end

    // Outputs decode from state (and the live hit vector in COMPARE) so a hit answers in the same cycle
    always_comb begin
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        way_idx       = victim;
        data_we       = '0;
        data_in_sel   = 1'b0;
        tag_we        = 1'b0;
        ld_dirty      = 1'b0;
        dirty_in      = 1'b0;
        address_sel   = 1'b1;
        err_rw        = 1'b0;
        err_multi_hit = 1'b0;
        case (state)
            IDLE: err_rw = rst_n & mem_read & mem_write;
            COMPARE: begin
                way_idx = hit_way;
                if (req && any_hit) begin
                    mem_resp      = 1'b1;
                    err_multi_hit = multi_hit;
                    if (mem_write) begin
                        data_we  = WAYS'(1) << hit_way;
                        ld_dirty = 1'b1;
                        dirty_in = 1'b1;
                    end
                end
            end
            WRITE_BACK: begin
                pmem_write  = 1'b1;
                address_sel = 1'b0;
            end
            ALLOCATE: pmem_read = 1'b1;
            FILL: begin
                data_we     = WAYS'(1) << victim;
                data_in_sel = 1'b1;
                tag_we      = 1'b1;
                ld_dirty    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l2_cache_ctrl_nway.sv
// Self-checking bench for l2_cache_ctrl_nway (WAYS=4, SETS=8): table-driven hits plus hand-built miss,
// write-back, reset and error sequences, with a scoreboard of expected completions.
module tb_l2_cache_ctrl_nway;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_read = 1'b0;
    logic       mem_write = 1'b0;
    logic [2:0] set_idx = '0;
    logic [3:0] hit_vec = '0;
    logic [3:0] valid_vec = '0;
    logic [3:0] dirty_vec = '0;
    logic       pmem_resp = 1'b0;
    logic       mem_resp, pmem_read, pmem_write, data_in_sel, tag_we;
    logic       ld_dirty, dirty_in, address_sel, err_rw, err_multi_hit;
    logic [1:0] way_idx;
    logic [3:0] data_we;

    int total = 0;
    int bad = 0;
    int mem_hold = 1;
    int wait_c = 0;
    int hi_c = 0;

    typedef struct {
        logic [1:0] way;
        logic [3:0] we;
        logic       ld;
        logic       din;
        logic       multi;
    } exp_t;

    typedef struct {
        string      name;
        logic       wr;
        logic [2:0] set;
        logic [3:0] hitv;
        logic [1:0] way;
        logic       multi;
    } vec_t;

    exp_t expq[$];
    vec_t vecs[7];

    l2_cache_ctrl_nway #(.WAYS(4), .SETS(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
        .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .way_idx(way_idx), .data_we(data_we),
        .data_in_sel(data_in_sel), .tag_we(tag_we), .ld_dirty(ld_dirty), .dirty_in(dirty_in),
        .address_sel(address_sel), .err_rw(err_rw), .err_multi_hit(err_multi_hit)
    );

    always #5 clk = ~clk;

    // Memory model: answers a line request after two cycles and holds pmem_resp for mem_hold cycles
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            pmem_resp = 1'b0;
            wait_c = 0;
            hi_c = 0;
        end else if (pmem_resp) begin
            hi_c++;
            if (hi_c >= mem_hold) pmem_resp = 1'b0;
        end else if (pmem_read || pmem_write) begin
            wait_c++;
            if (wait_c >= 2) begin
                pmem_resp = 1'b1;
                hi_c = 0;
                wait_c = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compareResp(input string name);
        exp_t e;
        if (expq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: mem_resp with empty scoreboard, got 1 expected 0", name);
        end else begin
            e = expq.pop_front();
            checkOutput({name, " way_idx"}, way_idx, e.way);
            checkOutput({name, " data_we"}, data_we, e.we);
            checkOutput({name, " ld_dirty"}, ld_dirty, e.ld);
            checkOutput({name, " dirty_in"}, dirty_in, e.din);
            checkOutput({name, " multi_hit"}, err_multi_hit, e.multi);
            checkOutput({name, " data_in_sel"}, data_in_sel, 1'b0);
        end
    endtask

    // One request from IDLE to completion; acts as the datapath by reporting a hit once the line is filled
    task automatic applyStimulus(input string name, input logic wr, input logic [2:0] set,
                                 input logic [3:0] hitv, input logic [3:0] valid,
                                 input logic [3:0] dirty, input logic [1:0] exp_way,
                                 input logic exp_multi, input int exp_wb, input int hold);
        exp_t       e;
        logic [3:0] onehot;
        int         cyc = 0;
        int         resp_cyc = -1;
        int         last_hi = -1;
        int         wb_n = 0;
        int         rd_n = 0;
        logic       prev_rd = 1'b0;
        logic       prev_wr = 1'b0;
        logic       fill_seen = 1'b0;
        logic       miss;
        miss = (hitv == 4'b0000);
        onehot = 4'b0001 << exp_way;
        mem_hold = hold;
        e.way = exp_way;
        e.we = wr ? onehot : 4'b0000;
        e.ld = wr;
        e.din = wr;
        e.multi = exp_multi;
        expq.push_back(e);
        mem_read = !wr;
        mem_write = wr;
        set_idx = set;
        hit_vec = hitv;
        valid_vec = valid;
        dirty_vec = dirty;
        while (resp_cyc < 0 && cyc < 60) begin
            @(negedge clk);
            if (pmem_resp) last_hi = cyc;
            if (pmem_write && !prev_wr) begin
                wb_n++;
                checkOutput({name, " wb way"}, way_idx, exp_way);
                checkOutput({name, " wb address_sel"}, address_sel, 1'b0);
            end
            if (pmem_read && !prev_rd) begin
                rd_n++;
                checkOutput({name, " alloc way"}, way_idx, exp_way);
                checkOutput({name, " alloc address_sel"}, address_sel, 1'b1);
            end
            prev_wr = pmem_write;
            prev_rd = pmem_read;
            if (data_in_sel && !fill_seen) begin
                fill_seen = 1'b1;
                checkOutput({name, " fill data_we"}, data_we, onehot);
                checkOutput({name, " fill tag_we"}, tag_we, 1'b1);
                checkOutput({name, " fill dirty_in"}, {ld_dirty, dirty_in}, 2'b10);
            end
            if (mem_resp) begin
                resp_cyc = cyc;
                compareResp(name);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (fill_seen) hit_vec = onehot;
        end
        mem_read = 1'b0;
        mem_write = 1'b0;
        hit_vec = 4'b0000;
        if (resp_cyc < 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: no mem_resp within 60 cycles, got 0 expected 1", name);
            expq.delete();
        end else if (miss) begin
            checkOutput({name, " wb count"}, wb_n, exp_wb);
            checkOutput({name, " alloc count"}, rd_n, 1);
            checkOutput({name, " fill seen"}, fill_seen, 1'b1);
            if (exp_wb == 0) checkOutput({name, " miss latency"}, resp_cyc - last_hi, 2);
        end else begin
            checkOutput({name, " hit latency"}, resp_cyc, 1);
            checkOutput({name, " pmem quiet"}, rd_n + wb_n, 0);
        end
    endtask

    initial begin
        bit found;
        vecs[0] = '{"rd_hit_w2",   1'b0, 3'd1, 4'b0100, 2'd2, 1'b0};
        vecs[1] = '{"wr_hit_w0",   1'b1, 3'd1, 4'b0001, 2'd0, 1'b0};
        vecs[2] = '{"multi_hit",   1'b0, 3'd2, 4'b0011, 2'd0, 1'b1};
        vecs[3] = '{"rd_hit_w3",   1'b0, 3'd2, 4'b1000, 2'd3, 1'b0};
        vecs[4] = '{"wr_multi",    1'b1, 3'd0, 4'b1010, 2'd1, 1'b1};
        vecs[5] = '{"set4_hit_w0", 1'b0, 3'd4, 4'b0001, 2'd0, 1'b0};
        vecs[6] = '{"set4_hit_w2", 1'b0, 3'd4, 4'b0100, 2'd2, 1'b0};

        // Reset values, with a conflicting request present to show err_rw is held off
        #1;
        mem_read = 1'b1;
        mem_write = 1'b1;
        #3;
        checkOutput("rst pmem", {pmem_read, pmem_write}, 2'b00);
        checkOutput("rst mem_resp", mem_resp, 1'b0);
        checkOutput("rst address_sel", address_sel, 1'b1);
        checkOutput("rst err_rw", err_rw, 1'b0);
        checkOutput("rst data_we", data_we, 4'b0000);
        checkOutput("rst ctrl", {tag_we, ld_dirty, dirty_in, data_in_sel, err_multi_hit}, 5'b0);
        checkOutput("rst way_idx", way_idx, 2'd0);
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Conflicting request: error pulse and no COMPARE
        mem_read = 1'b1;
        mem_write = 1'b1;
        set_idx = 3'd7;
        hit_vec = 4'b0001;
        @(negedge clk);
        checkOutput("err_rw pulse", err_rw, 1'b1);
        checkOutput("err_rw no resp", mem_resp, 1'b0);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        @(negedge clk);
        checkOutput("err_rw stayed idle", mem_resp, 1'b0);
        checkOutput("err_rw cleared", err_rw, 1'b0);
        @(negedge clk);
        checkOutput("after err read hit", mem_resp, 1'b1);
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        hit_vec = 4'b0000;

        for (int i = 0; i < 7; i++)
            applyStimulus(vecs[i].name, vecs[i].wr, vecs[i].set, vecs[i].hitv, 4'b1111,
                          4'b0000, vecs[i].way, vecs[i].multi, 0, 1);

        // Set 1 saw hits on way 2 then way 0, so the tree points at way 3
        applyStimulus("plru_s1_miss", 1'b0, 3'd1, 4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 0, 1);
        applyStimulus("wr_miss_s3", 1'b1, 3'd3, 4'b0000, 4'b1011, 4'b0000, 2'd2, 1'b0, 0, 1);
        // Set 4 saw hits on way 0 then way 2, so way 1 is the victim and it is dirty
        applyStimulus("wb_s4", 1'b0, 3'd4, 4'b0000, 4'b1111, 4'b0010, 2'd1, 1'b0, 1, 3);

        applyStimulus("fill_s6_w0", 1'b0, 3'd6, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 0, 2);
        applyStimulus("fill_s6_w1", 1'b0, 3'd6, 4'b0000, 4'b0001, 4'b0000, 2'd1, 1'b0, 0, 1);
        applyStimulus("fill_s6_w2", 1'b0, 3'd6, 4'b0000, 4'b0011, 4'b0000, 2'd2, 1'b0, 0, 3);
        applyStimulus("fill_s6_w3", 1'b0, 3'd6, 4'b0000, 4'b0111, 4'b0000, 2'd3, 1'b0, 0, 1);
        applyStimulus("lru_s6", 1'b0, 3'd6, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 0, 1);

        // Reset while ALLOCATE is requesting memory
        mem_hold = 2;
        mem_read = 1'b1;
        set_idx = 3'd5;
        hit_vec = 4'b0000;
        valid_vec = 4'b0000;
        dirty_vec = 4'b0000;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (pmem_read) found = 1'b1;
        end
        checkOutput("rst_mid reached alloc", found, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid pmem_read", pmem_read, 1'b0);
        checkOutput("rst_mid address_sel", address_sel, 1'b1);
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid idle", {mem_resp, pmem_read, pmem_write}, 3'b000);
        @(posedge clk);
        #1;
        applyStimulus("after_rst_miss", 1'b0, 3'd5, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 0, 2);

        checkOutput("scoreboard drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
